mul_q10_arbiter: RTL and testbench
==================================

Name: mul_q10_arbiter

Overview:
- Shares one pipelined signed Q22.10 fixed-point multiplier among NUM_REQ datapath requesters, such as FIR taps, demod and de-emphasis stages.
- Arbitration is round-robin with a valid/ready handshake on the request side.
- Results are returned tagged with the requester ID after a fixed latency.
- Replaces per-stage multipliers in the FM radio pipeline so that one DSP resource is time-shared.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PIPE_STAGES, 2, register stages from operand capture to result output (1..4). This equals the latency.
- FRAC_BITS, 10, fractional bits of the operand and result format.
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  one-hot grant, combinational from req_valid and the round-robin pointer.
- req_a  in  NUM_REQ*32  packed operand A; requester i occupies bits [32*i+31:32*i]; signed Q22.10.
- req_b  in  NUM_REQ*32  packed operand B, same packing as req_a.
- rsp_valid  out  NUM_REQ  one-hot result strobe; no backpressure, so the requester must consume it.
- rsp_id  out  ID_W  index of the requester owning rsp_data.
- rsp_data  out  32  signed Q22.10 product.
- inflight  out  3  number of operations currently in the pipeline (0..PIPE_STAGES).
- idle  out  1  high when inflight==0 and req_valid==0.

Behaviour:
- Reset, asserted asynchronously:
  - Pipeline valid bits cleared.
  - Round-robin pointer rr_ptr set to 0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, inflight=0, idle=1.
  - Any operation in flight is discarded and no response is issued for it.
- Arbitration:
  - Each cycle, grant the first asserted req_valid[k] searching k = rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[k]=1 only for that k. All req_ready are 0 if no request is valid.
  - The transfer occurs on a clock edge where req_valid[k] & req_ready[k] is high.
  - On transfer, rr_ptr <= (k+1) mod NUM_REQ. With no transfer, rr_ptr holds.
  - The pipeline never stalls, so at most one grant is issued per cycle and full throughput is one op per cycle.
  - A requester must hold its operands stable while req_valid=1 and it is not granted.
- Datapath:
  - Stage 1 captures a, b and the ID, and forms a 64-bit signed product of $signed(a) and $signed(b).
  - Dequantize as the signed product divided by 2^FRAC_BITS, truncating toward zero. Example: -1 maps to 0, not -1. This is an arithmetic shift plus a correction of +1 when the product is negative and its low FRAC_BITS bits are nonzero.
  - The result is the low 32 bits of the quotient; wrap-around on overflow.
  - Remaining stages are delay registers for the data, ID and valid bit.
- Latency:
  - An op accepted at edge t presents rsp_valid[id]=1, rsp_id and rsp_data in the cycle following edge t+PIPE_STAGES-1, i.e. exactly PIPE_STAGES edges after acceptance.
  - Responses are in acceptance order.
  - rsp_data and rsp_id hold their last value when rsp_valid=0.
- inflight:
  - Increments on accept, decrements on output.
  - Simultaneous accept and output leaves it unchanged.
- Boundaries:
  - A single requester requesting continuously is granted every cycle.
  - With all requesters active, the grant order is 0,1,2,...,NUM_REQ-1,0,...
  - A requester may drop req_valid without a transfer, and the arbiter then moves on to the next valid requester.

Optional Feature:
- MUL_Q10_SAT_EN defined: the dequantized 54-bit quotient saturates to [0x80000000, 0x7FFFFFFF] instead of wrapping. A sticky output sat_flag (1 bit, reset 0) sets on any saturation and clears only on reset.
- Undefined: the result wraps to the low 32 bits and the sat_flag port does not exist.

Test Plan:
- Basic multiply: req0 sends a=1536 (1.5), b=2048 (2.0). Require rsp_valid[0]=1, rsp_id=0 and rsp_data=3072 exactly PIPE_STAGES edges later. Then a=-1536, b=1024 must give -1536.
- Truncation toward zero: a=0xFFFFFFFF (-1/1024), b=1 must give 0. Then a=-3, b=512 (product -1536) must give -1 (-1.5 truncates to -1).
- Round-robin fairness: all 4 requesters hold valid for 8 cycles. Grants must be 0,1,2,3,0,1,2,3 and the responses must carry matching IDs in the same order.
- Overflow: a=b=0x7FFFFFFF. Without MUL_Q10_SAT_EN, rsp_data=0xFFC00000. With it, rsp_data=0x7FFFFFFF and sat_flag=1.
- Reset mid-operation: accept 2 ops back-to-back, then assert reset asynchronously for 1 cycle. Require no rsp_valid afterward, inflight=0, idle=1, and the next grant goes to requester 0.
- Sparse traffic: req2 sends only on alternate cycles while req1 sends continuously. Require req2 to be granted on each cycle it asserts req_valid, inflight to never exceed PIPE_STAGES, and no results to be lost.

Source files
------------

// File: rtl/mul_q10_arbiter.sv
// mul_q10_arbiter: round-robin shared signed Q22.10 multiplier with tagged responses.
// Optional saturation of the dequantized result: define MUL_Q10_SAT_EN.
module mul_q10_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int PIPE_STAGES = 2,
    parameter int FRAC_BITS   = 10,
    parameter int ID_W        = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_a,
    input  logic [NUM_REQ*32-1:0]  req_b,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [31:0]            rsp_data,
    output logic [2:0]             inflight,
`ifdef MUL_Q10_SAT_EN
    output logic                   sat_flag,
`endif
    output logic                   idle
);

    localparam int LAST = PIPE_STAGES - 1;

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   gnt_id;
    logic              gnt_any;
    logic [31:0]       sel_a;
    logic [31:0]       sel_b;
    logic signed [63:0] prod;
    logic              corr;
    logic [31:0]       res;

`ifdef MUL_Q10_SAT_EN
    localparam logic signed [63:0] SMAX = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [63:0] SMIN = 64'shFFFF_FFFF_8000_0000;
    logic signed [63:0] quo;
    logic              sat_hit;
`endif

    logic              pv  [PIPE_STAGES];
    logic [ID_W-1:0]   pid [PIPE_STAGES];
    logic [31:0]       pd  [PIPE_STAGES];

    // Round-robin search starting at rr_ptr; at most one grant per cycle.
    always_comb begin
        int k;
        k         = 0;
        req_ready = '0;
        gnt_id    = '0;
        gnt_any   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(rr_ptr) + i) % NUM_REQ;
            if (!gnt_any && req_valid[k]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'(k);
            end
        end
        if (gnt_any) req_ready[gnt_id] = 1'b1;
    end

    // Operand mux, full-width product and truncate-toward-zero dequantize.
    always_comb begin
        sel_a = req_a[int'(gnt_id)*32 +: 32];
        sel_b = req_b[int'(gnt_id)*32 +: 32];
        prod  = $signed({{32{sel_a[31]}}, sel_a}) *
                $signed({{32{sel_b[31]}}, sel_b});
        corr  = (prod < 0) && (prod[FRAC_BITS-1:0] != '0);
`ifdef MUL_Q10_SAT_EN
        quo     = (prod >>> FRAC_BITS) + $signed(64'(corr));
        sat_hit = 1'b0;
        res     = quo[31:0];
        if (quo > SMAX) begin
            res     = 32'h7FFF_FFFF;
            sat_hit = 1'b1;
        end else if (quo < SMIN) begin
            res     = 32'h8000_0000;
            sat_hit = 1'b1;
        end
`else
        res = 32'(prod >>> FRAC_BITS) + 32'(corr);
`endif
    end

    // Result pipeline; data and ID only move with a valid op so outputs hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                pv[s]  <= 1'b0;
                pid[s] <= '0;
                pd[s]  <= '0;
            end
        end else begin
            pv[0] <= gnt_any;
            if (gnt_any) begin
                pid[0] <= gnt_id;
                pd[0]  <= res;
            end
            for (int s = 1; s < PIPE_STAGES; s++) begin
                pv[s] <= pv[s-1];
                if (pv[s-1]) begin
                    pid[s] <= pid[s-1];
                    pd[s]  <= pd[s-1];
                end
            end
        end
    end

    // Pointer advance past the granted requester and in-flight bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr   <= '0;
            inflight <= '0;
        end else begin
            if (gnt_any) begin
                rr_ptr <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
            end
            inflight <= inflight + 3'(gnt_any) - 3'(pv[LAST]);
        end
    end

`ifdef MUL_Q10_SAT_EN
    // Sticky saturation indicator, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) sat_flag <= 1'b0;
        else if (gnt_any && sat_hit) sat_flag <= 1'b1;
    end
`endif

    // Response decode from the last pipeline stage.
    always_comb begin
        rsp_valid = '0;
        if (pv[LAST]) rsp_valid[pid[LAST]] = 1'b1;
        rsp_id   = pid[LAST];
        rsp_data = pd[LAST];
        idle     = (inflight == 3'd0) && (req_valid == '0);
    end

endmodule

// File: tb/tb_mul_q10_arbiter.sv
// tb_mul_q10_arbiter: directed stimulus with a queue-based reference model
// and an every-cycle compare process, plus literal expectations.
module tb_mul_q10_arbiter;

    localparam int N   = 4;
    localparam int P   = 2;
    localparam int FB  = 10;
    localparam int IDW = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*32-1:0]   req_a = '0;
    logic [N*32-1:0]   req_b = '0;
    logic [N-1:0]      rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_data;
    logic [2:0]        inflight;
    logic              idle;
`ifdef MUL_Q10_SAT_EN
    logic              sat_flag;
`endif

    mul_q10_arbiter #(
        .NUM_REQ(N), .PIPE_STAGES(P), .FRAC_BITS(FB), .ID_W(IDW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .rsp_valid(rsp_valid),
        .rsp_id(rsp_id),
        .rsp_data(rsp_data),
        .inflight(inflight),
`ifdef MUL_Q10_SAT_EN
        .sat_flag(sat_flag),
`endif
        .idle(idle)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        int          id;
        logic [31:0] d;
    } exp_t;

    exp_t q[$];
    int   ptr  = 0;
    int   cyc  = 0;
    logic msat = 1'b0;

    function automatic int pick(logic [N-1:0] v, int p);
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    // {saturated, result}: plain integer multiply and divide (C-style truncation)
    function automatic logic [32:0] model_mul(logic [31:0] a, logic [31:0] b);
        longint      pr;
        longint      qq;
        logic [63:0] u;
        pr = longint'($signed(a)) * longint'($signed(b));
        qq = pr / (longint'(1) << FB);
`ifdef MUL_Q10_SAT_EN
        if (qq > 64'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
        if (qq < -64'sd2147483648) return {1'b1, 32'h8000_0000};
`endif
        u = qq;
        return {1'b0, u[31:0]};
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            q.delete();
            ptr  = 0;
            msat = 1'b0;
        end else begin
            int          g;
            logic [32:0] r;
            cyc++;
            g = pick(req_valid, ptr);
            if (g >= 0) begin
                r = model_mul(req_a[g*32 +: 32], req_b[g*32 +: 32]);
                q.push_back('{due: cyc + P - 1, id: g, d: r[31:0]});
                if (r[32]) msat = 1'b1;
                ptr = (g + 1) % N;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        int           g;
        logic [N-1:0] er;
        logic [N-1:0] ev;
        er = '0;
        ev = '0;
        g  = pick(req_valid, ptr);
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", req_ready, er);
        chk("inflight", inflight, q.size());
        chk("idle", idle, (q.size() == 0 && req_valid == '0));
`ifdef MUL_Q10_SAT_EN
        chk("sat_flag", sat_flag, msat);
`endif
        if (q.size() > 0 && q[0].due == cyc) begin
            ev[q[0].id] = 1'b1;
            chk("rsp_valid", rsp_valid, ev);
            chk("rsp_id", rsp_id, q[0].id);
            chk("rsp_data", rsp_data, q[0].d);
            void'(q.pop_front());
        end else begin
            chk("rsp_idle", rsp_valid, 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(int id, logic [31:0] a, logic [31:0] b);
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
    endtask

    task automatic one(int id, logic [31:0] a, logic [31:0] b,
                       logic [31:0] exp, string nm);
        logic [N-1:0] e;
        e = '0;
        e[id] = 1'b1;
        @(posedge clock);
        #1;
        drive(id, a, b);
        req_valid = e;
        @(posedge clock);
        #1;
        req_valid = '0;
        repeat (P - 1) @(posedge clock);
        @(negedge clock);
        chk({nm, "_valid"}, rsp_valid, e);
        chk({nm, "_id"}, rsp_id, id);
        chk({nm, "_data"}, rsp_data, exp);
    endtask

    initial begin
        logic [N-1:0] e;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_idle", idle, 1);
        chk("rst_ready", req_ready, 0);
`ifdef MUL_Q10_SAT_EN
        chk("rst_sat", sat_flag, 0);
`endif

        one(0, 32'd1536, 32'd2048, 32'd3072, "mul_pos");
        one(0, -32'sd1536, 32'd1024, 32'hFFFF_FA00, "mul_neg");
        repeat (2) @(negedge clock);
        chk("hold_data", rsp_data, 32'hFFFF_FA00);
        chk("hold_id", rsp_id, 0);

        one(0, 32'hFFFF_FFFF, 32'd1, 32'd0, "trunc_tiny");
        one(0, -32'sd3, 32'd512, 32'hFFFF_FFFF, "trunc_half");

`ifdef MUL_Q10_SAT_EN
        one(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, "ovf");
        chk("ovf_sat", sat_flag, 1);
`else
        one(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFC0_0000, "ovf");
`endif

        // two back-to-back accepts from requester 1, then async reset
        @(posedge clock);
        #1;
        drive(1, 32'd5120, 32'd3072);
        req_valid = 4'b0010;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        req_valid = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (P + 1) begin
            @(negedge clock);
            chk("rst_no_rsp", rsp_valid, 0);
            chk("rst_mid_inflight", inflight, 0);
            chk("rst_mid_idle", idle, 1);
        end

        // all requesters active: grant order 0,1,2,3,0,1,2,3
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) drive(i, (i + 1) << FB, (i + 2) * 512);
        req_valid = '1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            e = '0;
            e[i % N] = 1'b1;
            chk("rr_grant", req_ready, e);
            @(posedge clock);
        end
        #1;
        req_valid = '0;
        repeat (P + 2) @(posedge clock);

        // sparse: req1 continuous, req2 every other cycle
        drive(1, 32'hFFFF_F000, 32'd3000);
        for (int i = 0; i < 12; i++) begin
            @(posedge clock);
            #1;
            drive(2, (i + 7) * 300, -32'sd700 * i);
            req_valid = (i % 2 == 1) ? 4'b0110 : 4'b0010;
            @(negedge clock);
            if (req_valid[2]) chk("sparse_req2", req_ready[2], 1);
            chk("inflight_le", inflight <= 3'(P), 1);
        end
        @(posedge clock);
        #1;
        req_valid = '0;
        repeat (P + 2) @(posedge clock);
        @(negedge clock);
        chk("drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
